div_seq: RTL

Multicycle 32-bit signed integer divider for the MIPS datapath. It turns subtraction around into repeated trial-subtract-and-restore, producing one quotient bit per clock. It sits beside the combinational ALU in the execute stage. The pipeline starts it with a one-cycle `ctrl_DIV` pulse and stalls until `data_resultRDY` pulses.

---
 rtl/div_pkg.sv | 32 +++
 rtl/div_step.sv | 25 ++
 rtl/div_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
// Used by div_seq and div_step; the remainder path is gated by DIV_SEQ_REMAINDER_EN.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_STEPS = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Per-operation facts decided at start and consumed at FIX.
  typedef struct packed {
    logic dz;
    logic ovf;
    logic neg_q;
  } div_flags_t;

  function automatic logic [DIV_WIDTH-1:0] neg2c(input logic [DIV_WIDTH-1:0] x);
    return ~x + DIV_WIDTH'(1);
  endfunction

  // INT_MIN maps onto itself, which reads correctly as the unsigned magnitude 2^31.
  function automatic logic [DIV_WIDTH-1:0] abs2c(input logic [DIV_WIDTH-1:0] x);
    return x[DIV_WIDTH-1] ? neg2c(x) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor over a 33-bit path, keep or restore.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   p_i,
  input  logic         msb_i,
  input  logic [W-1:0] divisor_i,
  output logic [W:0]   p_o,
  output logic         q_o
);

  logic [W:0] p_sh;
  logic [W:0] t;

  // P never exceeds the divisor, so p_i[W] is always clear; folding it into the
  // accept decision keeps the step well defined for any 33-bit P.
  always_comb begin
    p_sh = {p_i[W-1:0], msb_i};
    t    = p_sh - {1'b0, divisor_i};
    q_o  = ~t[W] | p_i[W];
    p_o  = q_o ? t : p_sh;
  end

endmodule

// File: rtl/div_seq.sv
// Multicycle 32-bit signed restoring divider, one quotient bit per clock.
// Define DIV_SEQ_REMAINDER_EN to drive data_remainder; otherwise it is tied to 0.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int            CW   = $clog2(DIV_STEPS);
  localparam logic [CW-1:0] LAST = CW'(DIV_STEPS - 1);

  div_state_t       state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   p_q;
  logic [WIDTH:0]   p_nxt;
  logic             q_bit;
  div_flags_t       flg_q;
  div_flags_t       flg_d;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             rdy_q;
`ifdef DIV_SEQ_REMAINDER_EN
  logic             sgnr_q;
  logic [WIDTH-1:0] rem_q;
`endif

  always_comb begin
    flg_d.dz    = (data_operandB == '0);
    flg_d.ovf   = (data_operandA == DIV_INT_MIN) && (data_operandB == '1);
    flg_d.neg_q = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
  end

  div_step #(.W(WIDTH)) u_step (
    .p_i       (p_q),
    .msb_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .p_o       (p_nxt),
    .q_o       (q_bit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      p_q      <= '0;
      flg_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
`ifdef DIV_SEQ_REMAINDER_EN
      sgnr_q   <= 1'b0;
      rem_q    <= '0;
`endif
    end else begin
      rdy_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (ctrl_DIV) begin
            flg_q   <= flg_d;
            exc_q   <= 1'b0;
            count_q <= '0;
            p_q     <= '0;
            dvs_q   <= abs2c(data_operandB);
            // Divide-by-zero parks the raw dividend here for the remainder and
            // borrows the FIX slot so RDY lands one edge after the start.
            dvd_q   <= flg_d.dz ? data_operandA : abs2c(data_operandA);
            state_q <= flg_d.dz ? FIX : ITER;
`ifdef DIV_SEQ_REMAINDER_EN
            sgnr_q  <= data_operandA[WIDTH-1];
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        ITER: begin
          p_q     <= p_nxt;
          dvd_q   <= {dvd_q[WIDTH-2:0], q_bit};
          count_q <= count_q + CW'(1);
          if (count_q == LAST) state_q <= FIX;
        end
        FIX: begin
          rdy_q    <= 1'b1;
          exc_q    <= flg_q.dz | flg_q.ovf;
          result_q <= flg_q.dz    ? '0 :
                      flg_q.neg_q ? neg2c(dvd_q) : dvd_q;
`ifdef DIV_SEQ_REMAINDER_EN
          rem_q    <= flg_q.dz ? dvd_q :
                      sgnr_q   ? neg2c(p_q[WIDTH-1:0]) : p_q[WIDTH-1:0];
`endif
          state_q  <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
`ifdef DIV_SEQ_REMAINDER_EN
  assign data_remainder = rem_q;
`else
  assign data_remainder = '0;
`endif

endmodule
